// File: rtl/ctrl_pipeline.sv
// rtl/ctrl_pipeline.sv - control pipeline registers with hazard, flush and optional forwarding (CTRL_PIPE_FWD_EN)
module ctrl_pipeline #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_reg_dst,
  input  logic             id_branch,
  input  logic             id_mem_read,
  input  logic             id_mem_to_reg,
  input  logic             id_mem_write,
  input  logic             id_alu_src,
  input  logic             id_reg_write,
  input  logic [1:0]       id_alu_op,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             ex_zero,
  output logic             stall,
  output logic             flush,
  output logic [1:0]       ex_alu_op,
  output logic             ex_alu_src,
  output logic             ex_reg_dst,
  output logic             mem_read,
  output logic             mem_write,
  output logic             pc_src,
  output logic             wb_reg_write,
  output logic             wb_mem_to_reg,
  output logic [REG_W-1:0] wb_dest
`ifdef CTRL_PIPE_FWD_EN
  ,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b
`endif
);

  logic             idex_valid, idex_reg_dst, idex_branch, idex_mem_read;
  logic             idex_mem_to_reg, idex_mem_write, idex_alu_src, idex_reg_write;
  logic [1:0]       idex_alu_op;
  logic [REG_W-1:0] idex_dest;

  logic             exmem_valid, exmem_taken, exmem_mem_read, exmem_mem_write;
  logic             exmem_mem_to_reg, exmem_reg_write;
  logic [REG_W-1:0] exmem_dest;

  logic             memwb_valid, memwb_reg_write, memwb_mem_to_reg;
  logic [REG_W-1:0] memwb_dest;

  logic             id_use_rt, idex_hit, hazard, load_id;
  logic [REG_W-1:0] id_dest;

  function automatic logic writes_reg(input logic v, input logic rw,
                                      input logic [REG_W-1:0] dest,
                                      input logic [REG_W-1:0] src);
    return v & rw & (dest != '0) & (dest == src);
  endfunction

  assign id_use_rt = ~id_alu_src | id_mem_write;
  assign id_dest   = id_reg_dst ? id_rd : id_rt;
  assign idex_hit  = writes_reg(idex_valid, idex_reg_write, idex_dest, id_rs) |
                     (id_use_rt & writes_reg(idex_valid, idex_reg_write, idex_dest, id_rt));

`ifdef CTRL_PIPE_FWD_EN
  logic [REG_W-1:0] idex_rs, idex_rt;
  logic             idex_use_rt;

  // Only a load still in EX cannot be forwarded in time.
  assign hazard = idex_hit & idex_mem_read;

  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (idex_valid && writes_reg(exmem_valid, exmem_reg_write, exmem_dest, idex_rs))
      forward_a = 2'b10;
    else if (idex_valid && writes_reg(memwb_valid, memwb_reg_write, memwb_dest, idex_rs))
      forward_a = 2'b01;
    if (idex_use_rt && writes_reg(exmem_valid, exmem_reg_write, exmem_dest, idex_rt))
      forward_b = 2'b10;
    else if (idex_use_rt && writes_reg(memwb_valid, memwb_reg_write, memwb_dest, idex_rt))
      forward_b = 2'b01;
  end
`else
  logic exmem_hit;

  assign exmem_hit = writes_reg(exmem_valid, exmem_reg_write, exmem_dest, id_rs) |
                     (id_use_rt & writes_reg(exmem_valid, exmem_reg_write, exmem_dest, id_rt));
  assign hazard    = idex_hit | exmem_hit;
`endif

  assign pc_src  = exmem_valid & exmem_taken;
  assign flush   = pc_src;
  assign stall   = id_valid & hazard & ~pc_src;
  assign load_id = id_valid & ~stall & ~pc_src;

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_valid       <= 1'b0;
      idex_reg_dst     <= 1'b0;
      idex_branch      <= 1'b0;
      idex_mem_read    <= 1'b0;
      idex_mem_to_reg  <= 1'b0;
      idex_mem_write   <= 1'b0;
      idex_alu_src     <= 1'b0;
      idex_reg_write   <= 1'b0;
      idex_alu_op      <= 2'b00;
      idex_dest        <= '0;
      exmem_valid      <= 1'b0;
      exmem_taken      <= 1'b0;
      exmem_mem_read   <= 1'b0;
      exmem_mem_write  <= 1'b0;
      exmem_mem_to_reg <= 1'b0;
      exmem_reg_write  <= 1'b0;
      exmem_dest       <= '0;
      memwb_valid      <= 1'b0;
      memwb_reg_write  <= 1'b0;
      memwb_mem_to_reg <= 1'b0;
      memwb_dest       <= '0;
`ifdef CTRL_PIPE_FWD_EN
      idex_rs          <= '0;
      idex_rt          <= '0;
      idex_use_rt      <= 1'b0;
`endif
    end else begin
      // A bubble is an all-zero entry, so unused fields never leak downstream.
      idex_valid       <= load_id;
      idex_reg_dst     <= load_id & id_reg_dst;
      idex_branch      <= load_id & id_branch;
      idex_mem_read    <= load_id & id_mem_read;
      idex_mem_to_reg  <= load_id & id_mem_to_reg;
      idex_mem_write   <= load_id & id_mem_write;
      idex_alu_src     <= load_id & id_alu_src;
      idex_reg_write   <= load_id & id_reg_write;
      idex_alu_op      <= load_id ? id_alu_op : 2'b00;
      idex_dest        <= load_id ? id_dest : '0;
`ifdef CTRL_PIPE_FWD_EN
      idex_rs          <= load_id ? id_rs : '0;
      idex_rt          <= load_id ? id_rt : '0;
      idex_use_rt      <= load_id & id_use_rt;
`endif
      exmem_valid      <= ~pc_src & idex_valid;
      exmem_taken      <= ~pc_src & idex_branch & ex_zero;
      exmem_mem_read   <= ~pc_src & idex_mem_read;
      exmem_mem_write  <= ~pc_src & idex_mem_write;
      exmem_mem_to_reg <= ~pc_src & idex_mem_to_reg;
      exmem_reg_write  <= ~pc_src & idex_reg_write;
      exmem_dest       <= pc_src ? '0 : idex_dest;
      memwb_valid      <= exmem_valid;
      memwb_reg_write  <= exmem_reg_write;
      memwb_mem_to_reg <= exmem_mem_to_reg;
      memwb_dest       <= exmem_dest;
    end
  end

  assign ex_alu_op     = idex_alu_op & {2{idex_valid}};
  assign ex_alu_src    = idex_alu_src & idex_valid;
  assign ex_reg_dst    = idex_reg_dst & idex_valid;
  assign mem_read      = exmem_mem_read & exmem_valid;
  assign mem_write     = exmem_mem_write & exmem_valid;
  assign wb_reg_write  = memwb_reg_write & memwb_valid;
  assign wb_mem_to_reg = memwb_mem_to_reg & memwb_valid;
  assign wb_dest       = memwb_dest & {REG_W{memwb_valid}};

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb/tb_ctrl_pipeline.sv - randomized and directed bench for ctrl_pipeline against an instruction-level model
module tb_ctrl_pipeline;

  typedef struct packed {
    logic       v;
    logic       reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    logic [1:0] alu_op;
    logic [4:0] rs, rt, rd;
  } ins_t;

`ifdef CTRL_PIPE_FWD_EN
  localparam int VW = 20;
`else
  localparam int VW = 16;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  ins_t cur_d = '0;
  logic cur_z = 1'b0;
  logic cur_rst = 1'b1;

  logic id_valid, id_reg_dst, id_branch, id_mem_read, id_mem_to_reg, id_mem_write;
  logic id_alu_src, id_reg_write, ex_zero, reset;
  logic [1:0] id_alu_op;
  logic [4:0] id_rs, id_rt, id_rd;
  logic stall, flush, ex_alu_src, ex_reg_dst, mem_read, mem_write, pc_src;
  logic wb_reg_write, wb_mem_to_reg;
  logic [1:0] ex_alu_op;
  logic [4:0] wb_dest;
`ifdef CTRL_PIPE_FWD_EN
  logic [1:0] forward_a, forward_b;
`endif

  assign reset         = cur_rst;
  assign ex_zero       = cur_z;
  assign id_valid      = cur_d.v;
  assign id_reg_dst    = cur_d.reg_dst;
  assign id_branch     = cur_d.branch;
  assign id_mem_read   = cur_d.mem_read;
  assign id_mem_to_reg = cur_d.mem_to_reg;
  assign id_mem_write  = cur_d.mem_write;
  assign id_alu_src    = cur_d.alu_src;
  assign id_reg_write  = cur_d.reg_write;
  assign id_alu_op     = cur_d.alu_op;
  assign id_rs         = cur_d.rs;
  assign id_rt         = cur_d.rt;
  assign id_rd         = cur_d.rd;

  ctrl_pipeline #(.REG_W(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_reg_dst(id_reg_dst), .id_branch(id_branch), .id_mem_read(id_mem_read),
    .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_alu_op(id_alu_op),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
    .stall(stall), .flush(flush), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_reg_dst(ex_reg_dst), .mem_read(mem_read), .mem_write(mem_write),
    .pc_src(pc_src), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_dest(wb_dest)
`ifdef CTRL_PIPE_FWD_EN
    , .forward_a(forward_a), .forward_b(forward_b)
`endif
  );

  logic [VW-1:0] obs_vec, exp_vec;
`ifdef CTRL_PIPE_FWD_EN
  assign obs_vec = {stall, flush, pc_src, ex_alu_op, ex_alu_src, ex_reg_dst, mem_read,
                    mem_write, wb_reg_write, wb_mem_to_reg, wb_dest, forward_a, forward_b};
`else
  assign obs_vec = {stall, flush, pc_src, ex_alu_op, ex_alu_src, ex_reg_dst, mem_read,
                    mem_write, wb_reg_write, wb_mem_to_reg, wb_dest};
`endif

  int n_tests = 0;
  int n_fail = 0;

  // Model: the instruction occupying each of EX, MEM and WB, plus the branch outcome seen in EX.
  ins_t m_ex = '0, m_mem = '0, m_wb = '0;
  logic m_taken = 1'b0;

  function automatic ins_t mk_r(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    ins_t i = '0;
    i.v = 1; i.reg_dst = 1; i.reg_write = 1; i.alu_op = 2'b10; i.rs = rs; i.rt = rt; i.rd = rd;
    return i;
  endfunction
  function automatic ins_t mk_lw(input logic [4:0] rt, input logic [4:0] rs);
    ins_t i = '0;
    i.v = 1; i.alu_src = 1; i.mem_read = 1; i.mem_to_reg = 1; i.reg_write = 1; i.rs = rs; i.rt = rt;
    return i;
  endfunction
  function automatic ins_t mk_sw(input logic [4:0] rt, input logic [4:0] rs);
    ins_t i = '0;
    i.v = 1; i.alu_src = 1; i.mem_write = 1; i.rs = rs; i.rt = rt;
    return i;
  endfunction
  function automatic ins_t mk_addi(input logic [4:0] rt, input logic [4:0] rs);
    ins_t i = '0;
    i.v = 1; i.alu_src = 1; i.reg_write = 1; i.rs = rs; i.rt = rt;
    return i;
  endfunction
  function automatic ins_t mk_beq(input logic [4:0] rs, input logic [4:0] rt);
    ins_t i = '0;
    i.v = 1; i.branch = 1; i.alu_op = 2'b01; i.rs = rs; i.rt = rt;
    return i;
  endfunction

  function automatic logic [4:0] dst(input ins_t x);
    return x.reg_dst ? x.rd : x.rt;
  endfunction
  function automatic logic writes(input ins_t x, input logic [4:0] r);
    return x.v && x.reg_write && dst(x) != 5'd0 && dst(x) == r;
  endfunction
  function automatic logic reads_rt(input ins_t x);
    return !x.alu_src || x.mem_write;
  endfunction
  function automatic logic depends(input ins_t cons, input ins_t prod);
    return writes(prod, cons.rs) || (reads_rt(cons) && writes(prod, cons.rt));
  endfunction

  function automatic logic m_stall(input ins_t d);
    logic hz;
`ifdef CTRL_PIPE_FWD_EN
    hz = depends(d, m_ex) && m_ex.mem_read;
`else
    hz = depends(d, m_ex) || depends(d, m_mem);
`endif
    return d.v && hz && !(m_mem.v && m_taken);
  endfunction

  function automatic logic [VW-1:0] model_vec(input ins_t d);
    logic pc;
    logic [15:0] base;
    pc = m_mem.v && m_taken;
    base = {m_stall(d), pc, pc, m_ex.alu_op, m_ex.alu_src, m_ex.reg_dst, m_mem.mem_read,
            m_mem.mem_write, m_wb.reg_write, m_wb.mem_to_reg, m_wb.v ? dst(m_wb) : 5'd0};
`ifdef CTRL_PIPE_FWD_EN
    begin
      logic [1:0] fa, fb;
      fa = !m_ex.v ? 2'b00 : writes(m_mem, m_ex.rs) ? 2'b10 : writes(m_wb, m_ex.rs) ? 2'b01 : 2'b00;
      fb = !(m_ex.v && reads_rt(m_ex)) ? 2'b00 :
           writes(m_mem, m_ex.rt) ? 2'b10 : writes(m_wb, m_ex.rt) ? 2'b01 : 2'b00;
      return {base, fa, fb};
    end
`else
    return base;
`endif
  endfunction

  task automatic advance();
    logic st, pc, nt;
    if (cur_rst) begin
      m_ex = '0; m_mem = '0; m_wb = '0; m_taken = 1'b0;
    end else begin
      st = m_stall(cur_d);
      pc = m_mem.v && m_taken;
      nt = m_ex.v && m_ex.branch && cur_z;
      m_wb = m_mem;
      m_mem = pc ? '0 : m_ex;
      m_taken = pc ? 1'b0 : nt;
      m_ex = (cur_d.v && !st && !pc) ? cur_d : '0;
    end
  endtask

  task automatic drive(input ins_t d, input logic z, input logic r);
    @(negedge clk);
    advance();
    cur_d = d; cur_z = z; cur_rst = r;
    #1;
    exp_vec = model_vec(cur_d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    drive(mk_r(5'd3, 5'd1, 5'd2), 1'b0, 1'b1);
    n_tests++;
    if (obs_vec !== '0) begin n_fail++; $display("FAIL reset_c1: got %h want 0", obs_vec); end
    drive(mk_r(5'd3, 5'd1, 5'd2), 1'b0, 1'b1);
    n_tests++;
    if (obs_vec !== '0) begin n_fail++; $display("FAIL reset_c2: got %h want 0", obs_vec); end
    drive(mk_r(5'd3, 5'd1, 5'd2), 1'b0, 1'b0);
    drive('0, 1'b0, 1'b0);
    n_tests++;
    if ({ex_alu_op, ex_reg_dst} !== 3'b101) begin
      n_fail++; $display("FAIL reset_first_ex: got %b want 101", {ex_alu_op, ex_reg_dst});
    end
  endtask

  task automatic test_propagation();
    idle(3);
    drive(mk_r(5'd3, 5'd1, 5'd2), 1'b0, 1'b0);
    drive('0, 1'b0, 1'b0);
    n_tests++;
    if (ex_alu_op !== 2'b10) begin n_fail++; $display("FAIL prop_ex_alu_op: got %b want 10", ex_alu_op); end
    idle(1);
    drive('0, 1'b0, 1'b0);
    n_tests++;
    if ({wb_reg_write, wb_dest} !== {1'b1, 5'd3}) begin
      n_fail++; $display("FAIL prop_wb: got %b/%0d want 1/3", wb_reg_write, wb_dest);
    end
    drive(mk_lw(5'd4, 5'd1), 1'b0, 1'b0);
    idle(1);
    drive('0, 1'b0, 1'b0);
    n_tests++;
    if (mem_read !== 1'b1) begin n_fail++; $display("FAIL prop_mem_read: got %b want 1", mem_read); end
    drive('0, 1'b0, 1'b0);
    n_tests++;
    if ({wb_mem_to_reg, wb_dest} !== {1'b1, 5'd4}) begin
      n_fail++; $display("FAIL prop_wb_load: got %b/%0d want 1/4", wb_mem_to_reg, wb_dest);
    end
  endtask

  task automatic test_hazard();
    idle(3);
`ifdef CTRL_PIPE_FWD_EN
    drive(mk_lw(5'd4, 5'd1), 1'b0, 1'b0);
    drive(mk_r(5'd6, 5'd4, 5'd2), 1'b0, 1'b0);
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL load_use_stall: got %b want 1", stall); end
    drive(mk_r(5'd6, 5'd4, 5'd2), 1'b0, 1'b0);
    n_tests++;
    if ({stall, ex_alu_op, mem_read} !== 4'b0001) begin
      n_fail++; $display("FAIL load_use_bubble: got %b want 0001", {stall, ex_alu_op, mem_read});
    end
    drive('0, 1'b0, 1'b0);
    n_tests++;
    if (forward_a !== 2'b01) begin n_fail++; $display("FAIL load_use_fwd_a: got %b want 01", forward_a); end
    drive(mk_addi(5'd5, 5'd1), 1'b0, 1'b0);
    drive(mk_sw(5'd5, 5'd2), 1'b0, 1'b0);
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_raw_nostall: got %b want 0", stall); end
    drive('0, 1'b0, 1'b0);
    n_tests++;
    if (forward_b !== 2'b10) begin n_fail++; $display("FAIL alu_raw_fwd_b: got %b want 10", forward_b); end
`else
    begin
      logic [2:0] seen;
      drive(mk_addi(5'd5, 5'd1), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        drive(mk_sw(5'd5, 5'd2), 1'b0, 1'b0);
        seen[2-i] = stall;
      end
      n_tests++;
      if (seen !== 3'b110) begin n_fail++; $display("FAIL raw_two_cycle_stall: got %b want 110", seen); end
    end
    idle(3);
    drive(mk_addi(5'd0, 5'd1), 1'b0, 1'b0);
    drive(mk_sw(5'd0, 5'd2), 1'b0, 1'b0);
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_r0_nostall: got %b want 0", stall); end
`endif
  endtask

  task automatic test_branch();
    idle(3);
    drive(mk_beq(5'd1, 5'd1), 1'b0, 1'b0);
    drive(mk_sw(5'd3, 5'd2), 1'b1, 1'b0);
    drive(mk_r(5'd7, 5'd1, 5'd2), 1'b0, 1'b0);
    n_tests++;
    if ({pc_src, flush, stall} !== 3'b110) begin
      n_fail++; $display("FAIL branch_taken: got %b want 110", {pc_src, flush, stall});
    end
    for (int i = 0; i < 4; i++) begin
      drive('0, 1'b0, 1'b0);
      n_tests++;
      if ({mem_write, wb_reg_write} !== 2'b00) begin
        n_fail++; $display("FAIL branch_squash_c%0d: got %b want 00", i, {mem_write, wb_reg_write});
      end
    end
  endtask

  task automatic test_simultaneous();
    idle(3);
    drive(mk_beq(5'd1, 5'd1), 1'b0, 1'b0);
    drive(mk_lw(5'd4, 5'd1), 1'b1, 1'b0);
    drive(mk_r(5'd6, 5'd4, 5'd2), 1'b0, 1'b0);
    n_tests++;
    if ({stall, flush} !== 2'b01) begin
      n_fail++; $display("FAIL flush_over_stall: got %b want 01", {stall, flush});
    end
    idle(3);
    drive(mk_lw(5'd4, 5'd1), 1'b0, 1'b0);
    drive(mk_r(5'd6, 5'd4, 5'd2), 1'b0, 1'b0);
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL pre_reset_stall: got %b want 1", stall); end
    drive(mk_r(5'd6, 5'd4, 5'd2), 1'b0, 1'b1);
    drive(mk_r(5'd6, 5'd4, 5'd2), 1'b0, 1'b0);
    n_tests++;
    if (obs_vec !== '0) begin n_fail++; $display("FAIL reset_mid_stall: got %h want 0", obs_vec); end
  endtask

  task automatic test_random();
    ins_t d;
    d = '0;
    for (int c = 0; c < 600; c++) begin
      if (!(exp_vec[VW-1] && !cur_rst)) begin
        case ($urandom_range(0, 6))
          0: d = '0;
          1: d = mk_r(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
          2: d = mk_lw(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
          3: d = mk_sw(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
          4: d = mk_addi(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
          5: d = mk_beq(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
          default: d = ins_t'($urandom);
        endcase
      end
      drive(d, 1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0);
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++; $display("FAIL random_c%0d: got %h want %h", c, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    exp_vec = '0;
    test_reset();
    test_propagation();
    test_hazard();
    test_branch();
    test_simultaneous();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
